gray_ptr_ctrl: RTL and testbench
================================

# gray_ptr_ctrl

Single-clock read/write pointer controller for a circular buffer, sequencing two Gray-code counters. It accepts push/pop requests, advances the write and read pointers in standard reflected Gray code, and produces the binary RAM addresses, full/empty flags, an occupancy count and sticky error flags. It sits between requesters and a 2^ADDR_WIDTH-entry storage array. Its Gray pointers are the values later handed to clock-domain-crossing logic.

## Interface
- ADDR_WIDTH, 3: buffer depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits wide, with one wrap bit. Legal range is 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- push  in  1  write request.
- pop  in  1  read request.
- wr_en  out  1  push accepted this cycle (combinational).
- rd_en  out  1  pop accepted this cycle (combinational).
- wr_addr  out  ADDR_WIDTH  binary write address (registered).
- rd_addr  out  ADDR_WIDTH  binary read address (registered).
- wr_ptr_gray  out  ADDR_WIDTH+1  Gray-coded write pointer (registered).
- rd_ptr_gray  out  ADDR_WIDTH+1  Gray-coded read pointer (registered).
- full  out  1  buffer holds 2^ADDR_WIDTH entries (registered).
- empty  out  1  buffer holds 0 entries (registered).
- count  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH (registered).
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

## Operation
- Internal state:
  - binary pointers wr_bin and rd_bin, each ADDR_WIDTH+1 bits, incrementing modulo 2^(ADDR_WIDTH+1);
  - registered Gray images g = b ^ (b >> 1).
- Outputs: wr_addr = wr_bin[ADDR_WIDTH-1:0]; rd_addr = rd_bin[ADDR_WIDTH-1:0].
- Acceptance, evaluated against the current registered flags:
  - wr_en = push & ~full & ~clear;
  - rd_en = pop & ~empty & ~clear.
- Simultaneous push and pop:
  - neither full nor empty: both accepted; count unchanged; both pointers advance.
  - full: pop accepted, push rejected.
  - empty: push accepted, pop rejected.
  - A same-cycle pop never frees space for a same-cycle push, and a same-cycle push never supplies data for a same-cycle pop.
- Error flags:
  - push & full & ~clear sets overflow;
  - pop & empty & ~clear sets underflow;
  - both stay set until clear or reset.
- Flags are computed from the next-state pointers and registered:
  - empty_next = (wr_gray_next == rd_gray_next);
  - full_next = wr_gray_next equals rd_gray_next with its two MSBs inverted and the remaining bits equal. For ADDR_WIDTH=1, invert both bits.
- count is registered as wr_bin_next - rd_bin_next, modulo 2^(ADDR_WIDTH+1).
- clear has priority over push and pop. It zeroes pointers, count, overflow and underflow; sets empty=1 and full=0; forces wr_en=rd_en=0.
- Every pointer step changes exactly one bit of the Gray pointer, including the wrap from 1000... back to 0.

## Timing
- Reset (resetn=0, asynchronous, takes effect without a clock edge):
  - all pointers, addresses, count, full, overflow and underflow = 0;
  - empty = 1.
- Reset is released synchronously to the next edge. The first accepted push is possible on the first edge with resetn=1.
- wr_en and rd_en are same-cycle combinational functions of the inputs and registered flags.
- All other outputs update one cycle after the accepting edge. Latency from request to pointer/flag update is 1 cycle.
- Reset asserted mid-operation discards all state immediately. A pending request in that cycle is lost and sets no error flag.
- clear and push/pop arriving in the same cycle: clear wins, and no error flag is set that cycle.

## Test plan
- Reset, ADDR_WIDTH=2: drive resetn=0 between edges. Outputs go to 0 immediately with empty=1. After release, 4 pushes give wr_ptr_gray 001, 011, 010, 110; then full=1 and count=4.
- Full: a 5th push gives wr_en=0 and overflow=1, wr_ptr_gray stays 110. Then push+pop in the same cycle gives rd_en=1, wr_en=0, count=3, full=0.
- Drain: pops until empty give rd_ptr_gray 001, 011, 010, 110 and empty=1. One extra pop gives rd_en=0 and underflow=1.
- Wrap: 8 push/pop pairs from empty. Each pointer walks 001, 011, 010, 110, 111, 101, 100, 000. Check that exactly one bit changes per step, count stays 0, and empty reasserts after each pop.
- Clear: with count=2 and overflow=1, assert clear together with push=1. Next cycle all pointers=0, count=0, empty=1, overflow=0, and wr_en was 0.
- Mid-operation reset: assert resetn=0 asynchronously while push=1 and count=3. Outputs go to reset values before the next edge, and no flag is set.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// Read/write pointer controller for a 2^ADDR_WIDTH-entry circular buffer.
// Pointers advance in binary and are exported as registered reflected-Gray images.
module gray_ptr_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write pointer is exactly one lap ahead: the top two Gray bits differ.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] r_wr_bin, r_rd_bin, r_wr_gray, r_rd_gray, r_count;
  logic          r_full, r_empty, r_overflow, r_underflow;

  logic [PW-1:0] w_wr_bin_next, w_rd_bin_next;
  logic [PW-1:0] w_wr_gray_next, w_rd_gray_next;
  logic          w_overflow_next, w_underflow_next;

  // Acceptance uses only the registered flags, so a same-cycle pop never makes room for a push.
  assign wr_en = push & ~r_full & ~clear;
  assign rd_en = pop & ~r_empty & ~clear;

  always_comb begin
    w_wr_bin_next    = r_wr_bin;
    w_rd_bin_next    = r_rd_bin;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    if (clear) begin
      w_wr_bin_next    = '0;
      w_rd_bin_next    = '0;
      w_overflow_next  = 1'b0;
      w_underflow_next = 1'b0;
    end else begin
      w_wr_bin_next    = r_wr_bin + PW'(wr_en);
      w_rd_bin_next    = r_rd_bin + PW'(rd_en);
      w_overflow_next  = r_overflow | (push & r_full);
      w_underflow_next = r_underflow | (pop & r_empty);
    end
  end

  assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);
  assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_bin    <= '0;
      r_rd_bin    <= '0;
      r_wr_gray   <= '0;
      r_rd_gray   <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_bin    <= w_wr_bin_next;
      r_rd_bin    <= w_rd_bin_next;
      r_wr_gray   <= w_wr_gray_next;
      r_rd_gray   <= w_rd_gray_next;
      r_count     <= w_wr_bin_next - w_rd_bin_next;
      r_full      <= (w_wr_gray_next == (w_rd_gray_next ^ FULL_MASK));
      r_empty     <= (w_wr_gray_next == w_rd_gray_next);
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign wr_addr     = r_wr_bin[ADDR_WIDTH-1:0];
  assign rd_addr     = r_rd_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = r_wr_gray;
  assign rd_ptr_gray = r_rd_gray;
  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl at ADDR_WIDTH=2: directed vector table, hand-written
// wrap/reset sequences, then random traffic against an occupancy-level model.
module tb_gray_ptr_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = AW + 1;
  localparam int NPTR  = 2 * DEPTH;

  logic          clk, resetn, clear, push, pop;
  logic          wr_en, rd_en, full, empty, overflow, underflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [PW-1:0] wr_ptr_gray, rd_ptr_gray, count;

  gray_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .push(push), .pop(pop),
    .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass, n_total;

  // reference model: pointer positions on a lap of 2*DEPTH, plus sticky flags
  int gt[NPTR];
  int m_wr, m_rd, m_ovf, m_unf;

  typedef struct {
    int p, q, c;
    int wen, ren;
    int cnt, wg, rg, wa, ra;
    int fl, em, ov, un;
  } vec_t;
  vec_t vecs[13];
  int   wrap_exp[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reflected Gray sequence built by mirroring, independent of any xor formula
  task automatic build_gray();
    int size;
    gt[0] = 0;
    gt[1] = 1;
    size  = 2;
    for (int b = 1; b < PW; b++) begin
      for (int i = 0; i < size; i++) gt[size + i] = gt[size - 1 - i] | (1 << b);
      size = size * 2;
    end
  endtask

  function automatic int occ();
    return (m_wr - m_rd + NPTR) % NPTR;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input int p, input int q, input int c, output int wen, output int ren);
    int o;
    o   = occ();
    wen = (p != 0 && o != DEPTH && c == 0) ? 1 : 0;
    ren = (q != 0 && o != 0 && c == 0) ? 1 : 0;
    if (c != 0) begin
      model_reset();
    end else begin
      if (p != 0 && o == DEPTH) m_ovf = 1;
      if (q != 0 && o == 0) m_unf = 1;
      m_wr = (m_wr + wen) % NPTR;
      m_rd = (m_rd + ren) % NPTR;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(count), occ());
    chk({tag, ".wgray"}, int'(wr_ptr_gray), gt[m_wr]);
    chk({tag, ".rgray"}, int'(rd_ptr_gray), gt[m_rd]);
    chk({tag, ".waddr"}, int'(wr_addr), m_wr % DEPTH);
    chk({tag, ".raddr"}, int'(rd_addr), m_rd % DEPTH);
    chk({tag, ".full"}, int'(full), (occ() == DEPTH) ? 1 : 0);
    chk({tag, ".empty"}, int'(empty), (occ() == 0) ? 1 : 0);
    chk({tag, ".ovf"}, int'(overflow), m_ovf);
    chk({tag, ".unf"}, int'(underflow), m_unf);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".waddr"}, int'(wr_addr), 0);
    chk({tag, ".raddr"}, int'(rd_addr), 0);
    chk({tag, ".wgray"}, int'(wr_ptr_gray), 0);
    chk({tag, ".rgray"}, int'(rd_ptr_gray), 0);
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".full"}, int'(full), 0);
    chk({tag, ".empty"}, int'(empty), 1);
    chk({tag, ".ovf"}, int'(overflow), 0);
    chk({tag, ".unf"}, int'(underflow), 0);
  endtask

  // driver: inputs change at the falling edge, registered outputs sampled 1 after the rising edge
  task automatic drive(input int p, input int q, input int c);
    @(negedge clk);
    push  = (p != 0);
    pop   = (q != 0);
    clear = (c != 0);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(input string tag, input int p, input int q, input int c);
    int wen, ren;
    drive(p, q, c);
    model_step(p, q, c, wen, ren);
    chk({tag, ".wr_en"}, int'(wr_en), wen);
    chk({tag, ".rd_en"}, int'(rd_en), ren);
    after_edge();
    check_model(tag);
  endtask

  initial begin
    logic [PW-1:0] prev;
    int            pw, qw;
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
    build_gray();
    model_reset();
    wrap_exp = '{1, 3, 2, 6, 7, 5, 4, 0};

    //            p q c wen ren cnt wg rg wa ra fl em ov un
    vecs[0]  = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 0, 2, 3, 0, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 0, 3, 2, 0, 3, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 0, 4, 6, 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 4, 6, 0, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 0, 1, 3, 6, 1, 0, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 0, 1, 2, 6, 3, 0, 2, 0, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 1, 1, 6, 2, 0, 3, 0, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 1, 0, 6, 6, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 6, 6, 0, 0, 0, 1, 1, 1};
    vecs[10] = '{1, 0, 0, 1, 0, 1, 7, 6, 1, 0, 0, 0, 1, 1};
    vecs[11] = '{1, 0, 0, 1, 0, 2, 5, 6, 2, 0, 0, 0, 1, 1};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    // power-on reset, checked between edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    resetn = 1'b1;

    // directed table: fill, overflow, push+pop at full, drain, underflow, clear
    for (int i = 0; i < 13; i++) begin
      int wen, ren;
      drive(vecs[i].p, vecs[i].q, vecs[i].c);
      model_step(vecs[i].p, vecs[i].q, vecs[i].c, wen, ren);
      chk($sformatf("vec%0d.wr_en", i), int'(wr_en), vecs[i].wen);
      chk($sformatf("vec%0d.rd_en", i), int'(rd_en), vecs[i].ren);
      after_edge();
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d.wgray", i), int'(wr_ptr_gray), vecs[i].wg);
      chk($sformatf("vec%0d.rgray", i), int'(rd_ptr_gray), vecs[i].rg);
      chk($sformatf("vec%0d.waddr", i), int'(wr_addr), vecs[i].wa);
      chk($sformatf("vec%0d.raddr", i), int'(rd_addr), vecs[i].ra);
      chk($sformatf("vec%0d.full", i), int'(full), vecs[i].fl);
      chk($sformatf("vec%0d.empty", i), int'(empty), vecs[i].em);
      chk($sformatf("vec%0d.ovf", i), int'(overflow), vecs[i].ov);
      chk($sformatf("vec%0d.unf", i), int'(underflow), vecs[i].un);
    end

    // wrap: push/pop pairs from empty walk both pointers through a full Gray lap
    for (int k = 0; k < 8; k++) begin
      prev = wr_ptr_gray;
      model_cycle($sformatf("wrap%0d.push", k), 1, 0, 0);
      chk($sformatf("wrap%0d.wbits", k), $countones(wr_ptr_gray ^ prev), 1);
      chk($sformatf("wrap%0d.wseq", k), int'(wr_ptr_gray), wrap_exp[k]);
      prev = rd_ptr_gray;
      model_cycle($sformatf("wrap%0d.pop", k), 0, 1, 0);
      chk($sformatf("wrap%0d.rbits", k), $countones(rd_ptr_gray ^ prev), 1);
      chk($sformatf("wrap%0d.rseq", k), int'(rd_ptr_gray), wrap_exp[k]);
    end

    // mid-operation asynchronous reset with a push pending
    for (int k = 0; k < 3; k++) model_cycle($sformatf("pre_rst%0d", k), 1, 0, 0);
    @(negedge clk);
    push = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    after_edge();
    check_reset_vals("rst_edge");
    @(negedge clk);
    resetn = 1'b1;
    push = 1'b0;
    model_reset();
    model_cycle("post_rst", 1, 0, 0);
    chk("post_rst.wgray1", int'(wr_ptr_gray), 1);

    // random traffic, alternating fill-biased and drain-biased segments
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 100; n++) begin
        pw = (seg % 2 == 0) ? 70 : 30;
        qw = 100 - pw;
        model_cycle($sformatf("rnd%0d_%0d", seg, n),
                    ($urandom_range(0, 99) < pw) ? 1 : 0,
                    ($urandom_range(0, 99) < qw) ? 1 : 0,
                    ($urandom_range(0, 39) == 0) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
